// File: rtl/uart_param_xcvr.sv
// uart_param_xcvr: full-duplex UART with runtime baud select, optional parity,
// 1/2 stop bits, 16x-oversampled receiver with false-start rejection and an
// RX FIFO that carries per-word parity/frame error flags.
module uart_param_xcvr #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned OVS       = 16,
  parameter int unsigned BAUD_DIV0 = 54,
  parameter int unsigned BAUD_DIV1 = 27,
  parameter int unsigned BAUD_DIV2 = 13,
  parameter int unsigned BAUD_DIV3 = 7,
  parameter int unsigned RX_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        sel,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  input  logic              rx,
  input  logic              rx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_overrun
);
  localparam int unsigned CNT_W = 16;
  localparam int unsigned OVS_W = $clog2(OVS);
  localparam int unsigned BIT_W = 4;
  localparam int unsigned AW    = $clog2(RX_DEPTH);
  localparam int unsigned ENT_W = DATA_W + 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // Terminal count of the tick divider for a given baud select.
  function automatic logic [CNT_W-1:0] f_div_last(input logic [1:0] s);
    case (s)
      2'd0:    f_div_last = CNT_W'(BAUD_DIV0 - 1);
      2'd1:    f_div_last = CNT_W'(BAUD_DIV1 - 1);
      2'd2:    f_div_last = CNT_W'(BAUD_DIV2 - 1);
      default: f_div_last = CNT_W'(BAUD_DIV3 - 1);
    endcase
  endfunction

  function automatic logic f_par_on(input logic [1:0] m);
    f_par_on = (m == 2'b01) || (m == 2'b10);
  endfunction

  // ---------------- TX ----------------
  tx_state_t         r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic [OVS_W-1:0]  r_tx_ovs;
  logic [BIT_W-1:0]  r_tx_bits;
  logic [DATA_W-1:0] r_tx_shift;
  logic              r_tx_par, r_tx_stop2, r_tx_stop_cnt, r_tx, r_tx_ready;
  logic [1:0]        r_tx_pmode, r_tx_sel;
  logic              w_tx_tick, w_tx_bit_end, w_tx_accept, w_tx_nxt, w_tx_ready_nxt;

  assign w_tx_tick    = (r_tx_cnt == f_div_last(r_tx_sel));
  assign w_tx_bit_end = w_tx_tick && (r_tx_ovs == OVS_W'(OVS - 1));
  assign w_tx_accept  = (r_tx_state == TX_IDLE) && tx_valid && r_tx_ready;

  // TX state register.
  always_ff @(posedge clk) begin
    if (reset) r_tx_state <= TX_IDLE;
    else       r_tx_state <= w_tx_state_nxt;
  end

  // TX next state and next serial/ready levels.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_nxt       = r_tx;
    w_tx_ready_nxt = r_tx_ready;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_nxt       = 1'b1;
        w_tx_ready_nxt = 1'b1;
        if (w_tx_accept) begin
          w_tx_state_nxt = TX_START;
          w_tx_nxt       = 1'b0;
          w_tx_ready_nxt = 1'b0;
        end
      end
      TX_START: if (w_tx_bit_end) begin
        w_tx_state_nxt = TX_DATA;
        w_tx_nxt       = r_tx_shift[0];
      end
      TX_DATA: if (w_tx_bit_end) begin
        if (r_tx_bits == BIT_W'(DATA_W - 1)) begin
          if (f_par_on(r_tx_pmode)) begin
            w_tx_state_nxt = TX_PARITY;
            w_tx_nxt       = r_tx_par;
          end else begin
            w_tx_state_nxt = TX_STOP;
            w_tx_nxt       = 1'b1;
          end
        end else begin
          w_tx_nxt = r_tx_shift[1];
        end
      end
      TX_PARITY: if (w_tx_bit_end) begin
        w_tx_state_nxt = TX_STOP;
        w_tx_nxt       = 1'b1;
      end
      TX_STOP: if (w_tx_bit_end && !(r_tx_stop2 && !r_tx_stop_cnt)) begin
        w_tx_state_nxt = TX_IDLE;
        w_tx_ready_nxt = 1'b1;
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // TX datapath: frame config capture, bit timing and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx <= 1'b1;  r_tx_ready <= 1'b0;  r_tx_cnt <= '0;  r_tx_ovs <= '0;
      r_tx_bits <= '0;  r_tx_shift <= '0;  r_tx_par <= 1'b0;  r_tx_pmode <= '0;
      r_tx_stop2 <= 1'b0;  r_tx_sel <= '0;  r_tx_stop_cnt <= 1'b0;
    end else begin
      r_tx       <= w_tx_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      if (w_tx_accept) begin
        r_tx_shift    <= tx_data;
        r_tx_par      <= (^tx_data) ^ (parity_mode == 2'b10);
        r_tx_pmode    <= parity_mode;
        r_tx_stop2    <= stop2;
        r_tx_sel      <= sel;
        r_tx_cnt      <= '0;
        r_tx_ovs      <= '0;
        r_tx_bits     <= '0;
        r_tx_stop_cnt <= 1'b0;
      end else if (r_tx_state != TX_IDLE) begin
        r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + CNT_W'(1);
        if (w_tx_tick) r_tx_ovs <= w_tx_bit_end ? '0 : r_tx_ovs + OVS_W'(1);
        if (w_tx_bit_end && r_tx_state == TX_DATA) begin
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_bits  <= r_tx_bits + BIT_W'(1);
        end
        if (w_tx_bit_end && r_tx_state == TX_STOP) r_tx_stop_cnt <= 1'b1;
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_t         r_rx_state, w_rx_state_nxt;
  logic              r_rx_s1, r_rx_s2;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic [1:0]        r_rx_sel, r_rx_sel_prev, r_rx_pmode, w_rx_sel;
  logic [OVS_W-1:0]  r_rx_ovs;
  logic [BIT_W-1:0]  r_rx_bits;
  logic [DATA_W-1:0] r_rx_shift;
  logic              r_rx_perr;
  logic              w_rx_in, w_rx_sel_chg, w_rx_tick, w_rx_half, w_rx_full;
  logic              w_push, w_rx_ferr;

  // Live select while idle so the sampling phase is ready for a start edge.
  assign w_rx_in      = r_rx_s2;
  assign w_rx_sel     = (r_rx_state == RX_IDLE) ? sel : r_rx_sel;
  assign w_rx_sel_chg = (w_rx_sel != r_rx_sel_prev);
  assign w_rx_tick    = !w_rx_sel_chg && (r_rx_cnt == f_div_last(w_rx_sel));
  assign w_rx_half    = w_rx_tick && (r_rx_ovs == OVS_W'(OVS / 2 - 1));
  assign w_rx_full    = w_rx_tick && (r_rx_ovs == OVS_W'(OVS - 1));

  // RX state register.
  always_ff @(posedge clk) begin
    if (reset) r_rx_state <= RX_IDLE;
    else       r_rx_state <= w_rx_state_nxt;
  end

  // RX next state, FIFO push and frame-error decision.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_push         = 1'b0;
    w_rx_ferr      = 1'b0;
    case (r_rx_state)
      RX_IDLE:   if (w_rx_tick && !w_rx_in) w_rx_state_nxt = RX_START;
      RX_START:  if (w_rx_half) w_rx_state_nxt = w_rx_in ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rx_full && r_rx_bits == BIT_W'(DATA_W - 1))
                   w_rx_state_nxt = f_par_on(r_rx_pmode) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_full) w_rx_state_nxt = RX_STOP;
      RX_STOP: if (w_rx_full) begin
        w_push         = 1'b1;
        w_rx_ferr      = !w_rx_in;
        w_rx_state_nxt = w_rx_in ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (w_rx_in) w_rx_state_nxt = RX_IDLE;
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX datapath: synchroniser, tick divider, mid-bit sampling.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;  r_rx_s2 <= 1'b1;  r_rx_cnt <= '0;  r_rx_sel <= '0;
      r_rx_sel_prev <= '0;  r_rx_pmode <= '0;  r_rx_ovs <= '0;  r_rx_bits <= '0;
      r_rx_shift <= '0;  r_rx_perr <= 1'b0;
    end else begin
      r_rx_s1       <= rx;
      r_rx_s2       <= r_rx_s1;
      r_rx_sel_prev <= w_rx_sel;
      r_rx_cnt      <= (w_rx_sel_chg || w_rx_tick) ? '0 : r_rx_cnt + CNT_W'(1);
      case (r_rx_state)
        RX_IDLE: if (w_rx_tick && !w_rx_in) begin
          r_rx_sel   <= sel;
          r_rx_pmode <= parity_mode;
          r_rx_ovs   <= '0;
          r_rx_bits  <= '0;
          r_rx_perr  <= 1'b0;
        end
        RX_START: if (w_rx_tick) r_rx_ovs <= w_rx_half ? '0 : r_rx_ovs + OVS_W'(1);
        RX_DATA, RX_PARITY, RX_STOP: begin
          if (w_rx_tick) r_rx_ovs <= w_rx_full ? '0 : r_rx_ovs + OVS_W'(1);
          if (w_rx_full && r_rx_state == RX_DATA) begin
            r_rx_shift <= {w_rx_in, r_rx_shift[DATA_W-1:1]};
            r_rx_bits  <= r_rx_bits + BIT_W'(1);
          end
          if (w_rx_full && r_rx_state == RX_PARITY)
            r_rx_perr <= (^r_rx_shift) ^ w_rx_in ^ (r_rx_pmode == 2'b10);
        end
        default: ;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [ENT_W-1:0] r_mem [RX_DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic             r_overrun;
  logic             w_empty, w_full, w_pop, w_wr;
  logic [ENT_W-1:0] w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && rx_ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  // Show-ahead FIFO storage, pointers and overrun pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RX_DEPTH; i++) r_mem[i] <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= {r_rx_shift, r_rx_perr, w_rx_ferr};
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
      r_overrun <= w_push && w_full && !w_pop;
    end
  end

  assign tx            = r_tx;
  assign tx_ready      = r_tx_ready;
  assign rx_valid      = !w_empty;
  assign rx_data       = w_head[ENT_W-1:2];
  assign rx_parity_err = w_head[1];
  assign rx_frame_err  = w_head[0];
  assign rx_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_param_xcvr.sv
// tb_uart_param_xcvr: directed checks of TX framing, loopback, RX error flags,
// break handling, FIFO overrun, false-start rejection and reset mid-frame.
`timescale 1ns/1ps
module tb_uart_param_xcvr;
  localparam int BIT_CLKS = 112;  // sel=3: 7 clocks/tick * 16 ticks

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sel = 2'd3;
  logic [1:0] parity_mode = 2'b00;
  logic       stop2 = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx;
  logic       rx_line, rx_drv = 1'b1, loop_en = 1'b0;
  logic       rx_ready = 1'b0;
  logic       rx_valid, rx_parity_err, rx_frame_err, rx_overrun;
  logic [7:0] rx_data;

  int n_total = 0;
  int n_bad = 0;
  int n_ovr = 0;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_param_xcvr dut (
    .clk(clk), .reset(reset), .sel(sel), .parity_mode(parity_mode), .stop2(stop2),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx(tx),
    .rx(rx_line), .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rx_overrun === 1'b1) n_ovr <= n_ovr + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rx_valid(input string tag, input int max_cyc);
    int n = 0;
    while (rx_valid !== 1'b1 && n < max_cyc) begin @(negedge clk); n++; end
    check(tag, 32'(rx_valid), 1);
  endtask

  task automatic wait_tx_ready(input string tag, input int max_cyc);
    int n = 0;
    while (tx_ready !== 1'b1 && n < max_cyc) begin @(negedge clk); n++; end
    check(tag, 32'(tx_ready), 1);
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic drive_bits(input logic b, input int n);
    rx_drv = b;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  // Start, 8 data bits LSB first, optional parity (flip inverts it), one stop bit.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic flip,
                            input logic stop_b);
    logic p;
    drive_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bits(d[i], 1);
    if (pm == 2'b01 || pm == 2'b10) begin
      p = (^d) ^ (pm == 2'b10) ^ flip;
      drive_bits(p, 1);
    end
    drive_bits(stop_b, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    int         ovr_base;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_flags", {30'd0, rx_parity_err, rx_frame_err}, 0);
    check("rst_overrun", 32'(rx_overrun), 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(tx_ready), 1);

    // TX 0xA5, no parity, one stop bit: each level exactly 112 clocks
    frame    = {1'b1, 8'hA5, 1'b0};
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    for (int i = 0; i <= 10 * BIT_CLKS; i++) begin
      @(negedge clk);
      if (i == 0) tx_valid = 1'b0;
      if (i < 10 * BIT_CLKS && (i % BIT_CLKS == 0 || i % BIT_CLKS == BIT_CLKS - 1))
        check($sformatf("tx_bit%0d_%0d", i / BIT_CLKS, i % BIT_CLKS), 32'(tx), 32'(frame[i / BIT_CLKS]));
      if (i == 10 * BIT_CLKS - 1) check("tx_ready_low", 32'(tx_ready), 0);
      if (i == 10 * BIT_CLKS) begin
        check("tx_ready_back", 32'(tx_ready), 1);
        check("tx_idle_high", 32'(tx), 1);
      end
    end

    // Loopback, even parity, 0xA5 -> parity bit 0
    loop_en     = 1'b1;
    parity_mode = 2'b01;
    tx_data     = 8'hA5;
    tx_valid    = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (9 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    check("lb_par_bit", 32'(tx), 0);
    wait_rx_valid("lb_valid", 400);
    check("lb_data", 32'(rx_data), 32'hA5);
    check("lb_perr", 32'(rx_parity_err), 0);
    check("lb_ferr", 32'(rx_frame_err), 0);
    pop();
    check("lb_popped", 32'(rx_valid), 0);
    wait_tx_ready("lb_tx_done", 400);
    loop_en = 1'b0;
    drive_bits(1'b1, 1);

    // Odd parity 0x3C with parity bit inverted
    parity_mode = 2'b10;
    send_frame(8'h3C, 2'b10, 1'b1, 1'b1);
    wait_rx_valid("odd_valid", 20);
    check("odd_data", 32'(rx_data), 32'h3C);
    check("odd_perr", 32'(rx_parity_err), 1);
    check("odd_ferr", 32'(rx_frame_err), 0);
    pop();
    drive_bits(1'b1, 1);

    // 0x55 with stop bit 0, then line held low: break must not restart RX
    parity_mode = 2'b00;
    send_frame(8'h55, 2'b00, 1'b0, 1'b0);
    wait_rx_valid("brk_valid", 20);
    check("brk_data", 32'(rx_data), 32'h55);
    check("brk_ferr", 32'(rx_frame_err), 1);
    check("brk_perr", 32'(rx_parity_err), 0);
    pop();
    drive_bits(1'b0, 3);
    check("brk_no_push_low", 32'(rx_valid), 0);
    drive_bits(1'b1, 10);
    check("brk_no_false_frame", 32'(rx_valid), 0);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1);
    wait_rx_valid("brk_recover_valid", 20);
    check("brk_recover_data", 32'(rx_data), 32'h5A);
    check("brk_recover_ferr", 32'(rx_frame_err), 0);
    pop();

    // Five frames into a 4-deep FIFO with no pops
    ovr_base = n_ovr;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 2'b00, 1'b0, 1'b1);
      if (k == 4) check("ovr_none_at4", 32'(n_ovr - ovr_base), 0);
    end
    check("ovr_once", 32'(n_ovr - ovr_base), 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("fifo_valid%0d", k), 32'(rx_valid), 1);
      check($sformatf("fifo_data%0d", k), 32'(rx_data), 32'(k));
      pop();
    end
    check("fifo_empty", 32'(rx_valid), 0);

    // Glitch of 3 oversample ticks: no push, receiver still works after
    rx_drv = 1'b0;
    repeat (21) @(negedge clk);
    drive_bits(1'b1, 2);
    check("glitch_no_push", 32'(rx_valid), 0);
    send_frame(8'h81, 2'b00, 1'b0, 1'b1);
    wait_rx_valid("glitch_recover_valid", 20);
    check("glitch_recover_data", 32'(rx_data), 32'h81);
    pop();

    // Reset in the middle of a TX frame
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (300) @(negedge clk);
    check("rst_mid_pre_tx", 32'(tx), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", 32'(tx), 1);
    check("rst_mid_ready", 32'(tx_ready), 0);
    @(negedge clk);
    check("rst_mid_ready_hold", 32'(tx_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rel_ready", 32'(tx_ready), 1);
    check("rst_rel_tx", 32'(tx), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_param_xcvr.md
Name: uart_param_xcvr

Overview:
- Full-duplex UART transceiver, successor to the fixed-format UART core.
- Generalises data width, adds runtime baud select (4-entry divisor table), parity mode (none/even/odd), 1/2 stop bits, 16x-oversampled receiver with false-start rejection, and an RX FIFO with per-word error flags and overrun reporting.
- Sits between the system-side valid/ready interface and the serial pins.

Parameters:
- DATA_W, 8, data bits per frame (5..9).
- OVS, 16, oversample ticks per bit (even, >=8).
- BAUD_DIV0, 54, clocks per oversample tick when sel=0.
- BAUD_DIV1, 27, clocks per tick when sel=1.
- BAUD_DIV2, 13, clocks per tick when sel=2.
- BAUD_DIV3, 7, clocks per tick when sel=3.
- RX_DEPTH, 4, RX FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- sel  in  2  baud divisor select
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- stop2  in  1  1 = two stop bits on TX
- tx_valid  in  1  TX word offered
- tx_data  in  DATA_W  TX word
- tx_ready  out  1  TX idle, can accept a word
- tx  out  1  serial out, idle high
- rx  in  1  serial in, asynchronous
- rx_ready  in  1  consumer pops FIFO head
- rx_valid  out  1  FIFO non-empty
- rx_data  out  DATA_W  FIFO head data
- rx_parity_err  out  1  head word had parity mismatch
- rx_frame_err  out  1  head word had stop bit = 0
- rx_overrun  out  1  one-cycle pulse: word dropped, FIFO full

Behaviour:
- Reset (sync, one clk edge):
  - tx=1, tx_ready=0, rx_valid=0, rx_data=0, both error flags 0, rx_overrun=0.
  - FIFO emptied, both FSMs IDLE, synchroniser flops = 1, tick counter = 0.
  - tx_ready rises on the first edge after reset deasserts.
  - Reset mid-frame aborts the frame; tx=1 after that edge.
- Tick generator:
  - Counter counts 0..BAUD_DIV[sel]-1 and pulses tick on the wrap.
  - A change of sel restarts the counter at 0.
  - sel, parity_mode and stop2 are captured at frame start (TX accept / RX start detect) and are stable for the whole frame.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Accept when tx_valid && tx_ready: latch tx_data, tx_ready=0, tx=0 from the next edge.
  - Each bit lasts OVS ticks; data is sent LSB first.
  - PARITY state is skipped when parity is none. Even parity bit = XOR of data; odd = its inverse.
  - STOP lasts 1 or 2 bit times with tx=1, then IDLE with tx_ready=1 on the next edge.
  - tx_valid held high gives back-to-back frames with no extra idle bit.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: synced rx=0 on a tick enters START and captures config.
  - START: resample at tick OVS/2. If 1, false start: back to IDLE, nothing pushed.
  - Data, parity and stop bits are sampled every OVS ticks after that point (mid-bit).
  - Only the first stop bit is checked; frame_err = stop sample 0.
  - Push {data, parity_err, frame_err} on the stop-sample cycle.
  - After a frame_err, enter WAIT_HIGH until synced rx=1, then IDLE (break handling).
- RX FIFO:
  - Show-ahead: rx_valid = !empty; rx_data and flags show the head entry.
  - Pop on rx_valid && rx_ready.
  - Pushed word appears on rx_valid the edge after the push.
  - Push while full and no pop: word dropped, rx_overrun=1 for one cycle, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun.
  - Pointers are log2(RX_DEPTH)+1 bits and wrap naturally.

Test Plan:
- sel=3, parity none, stop2=0, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each level 112 clocks; tx_ready low 1120 clocks, then 1.
- Loopback tx->rx, sel=3, even parity, 0xA5 -> parity bit 0; rx_data=0xA5, rx_valid=1, both error flags 0; rx_ready pop -> rx_valid=0.
- Drive an odd-parity frame 0x3C with the parity bit inverted -> rx_data=0x3C with rx_parity_err=1, rx_frame_err=0.
- Frame 0x55 with stop bit 0, then line held low 3 bit times -> rx_frame_err=1; no new start detected until rx returns high.
- Five frames (0x01..0x05) with rx_ready=0 -> one rx_overrun pulse at frame 5; pops return 0x01..0x04 in order, then rx_valid=0.
- rx low for only 3 oversample ticks -> nothing pushed. Separately, assert reset mid-TX frame -> tx=1 next edge, tx_ready=0 during reset and 1 one edge after release.
